// File: rtl/rv32e_ifetch.sv
// RV32E instruction fetch unit: single-outstanding program-memory reader feeding a small prefetch FIFO.
// Optional feature: define IFETCH_MISALIGN_CHECK_EN to flag misaligned redirects via inst_misaligned.
module rv32e_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic        inst_misaligned
`endif
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LAST_CNT = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_ptr_q, fetch_ptr_d;
    logic        halted_q, halted_d;
    logic        mem_req_d;
    logic [31:0] mem_addr_d;
    logic        restart;

    logic [AW:0]   count_q, count_after_pop;
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic        push, pop, bad_redirect;
    logic [31:0] redirect_ptr;

    assign redirect_ptr    = redirect_pc & ~32'h3;
    assign inst_valid      = (count_q != '0);
    assign pop             = inst_valid && inst_ready;
    // A redirect wins over a returning word: that word belongs to the abandoned stream.
    assign push            = (state_q == S_REQ) && mem_ack && !redirect_valid;
    assign count_after_pop = count_q - (AW + 1)'(pop);

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    assign bad_redirect = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            fetch_ptr_q <= RESET_PC;
            halted_q    <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_ptr_q <= fetch_ptr_d;
            halted_q    <= halted_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        fetch_ptr_d = fetch_ptr_q;
        halted_d    = halted_q;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;
        restart     = 1'b0;

        if (redirect_valid) begin
            fetch_ptr_d = redirect_ptr;
            halted_d    = bad_redirect;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!redirect_valid && !halted_q && (count_after_pop < FULL_CNT)) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_ptr_q;
                end
            end
            S_REQ: begin
                if (mem_ack && !redirect_valid) begin
                    fetch_ptr_d = fetch_ptr_q + 32'd4;
                    if (count_after_pop < LAST_CNT) begin
                        mem_addr_d = fetch_ptr_q + 32'd4;
                    end else begin
                        state_d   = S_IDLE;
                        mem_req_d = 1'b0;
                    end
                end else if (mem_ack) begin
                    restart = 1'b1;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                restart = mem_ack;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // Discarded response: resume at the (possibly just redirected) pointer unless halted.
        if (restart) begin
            if (halted_d) begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end else begin
                state_d    = S_REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = fetch_ptr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (redirect_valid) begin
            count_q  <= (AW + 1)'(bad_redirect);
            rd_ptr_q <= '0;
            wr_ptr_q <= AW'(bad_redirect);
        end else begin
            count_q  <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            wr_ptr_q <= wr_ptr_q + AW'(push);
        end
    end

    // NOTE: FIFO storage is deliberately not reset; outputs are masked by inst_valid instead.
    always_ff @(posedge clk) begin
        if (bad_redirect) begin
            pc_q[0]   <= redirect_pc;
            data_q[0] <= '0;
        end else if (push) begin
            pc_q[wr_ptr_q]   <= mem_addr;
            data_q[wr_ptr_q] <= mem_rdata;
        end
    end

    assign inst_pc   = inst_valid ? pc_q[rd_ptr_q]   : '0;
    assign inst_data = inst_valid ? data_q[rd_ptr_q] : '0;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic mis_q [DEPTH];

    always_ff @(posedge clk) begin
        if (bad_redirect) begin
            mis_q[0] <= 1'b1;
        end else if (push) begin
            mis_q[wr_ptr_q] <= 1'b0;
        end
    end

    assign inst_misaligned = inst_valid ? mis_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_rv32e_ifetch.sv
// Directed bench for rv32e_ifetch: memory model with selectable latency or manual acks.
module tb_rv32e_ifetch;

    localparam logic [31:0] K = 32'h5A5A_F00F;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        inst_misaligned;
`endif

    logic auto_en = 1'b1;
    logic man_ack = 1'b0;
    int   lat = 0;
    int   wait_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    rv32e_ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef IFETCH_MISALIGN_CHECK_EN
        ,
        .inst_misaligned(inst_misaligned)
`endif
    );

    always #5 clk = ~clk;

    // Memory: word content is address ^ K; ack after `lat` wait cycles, or manual.
    assign mem_rdata = mem_addr ^ K;
    assign mem_ack   = auto_en ? (mem_req && (wait_cnt >= lat)) : man_ack;

    always_ff @(posedge clk) begin
        wait_cnt <= (!mem_req || mem_ack) ? 0 : wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0;
        man_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then zero-wait streaming.
        inst_ready = 1'b1;
        lat = 0;
        repeat (3) tick();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_data", inst_data, 0);
        check("rst_pc", inst_pc, 0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("seq_req", mem_req, 1);
            check("seq_addr", mem_addr, 32'(4 * i));
            if (i > 0) begin
                check("seq_valid", inst_valid, 1);
                check("seq_pc", inst_pc, 32'(4 * (i - 1)));
                check("seq_data", inst_data, 32'(4 * (i - 1)) ^ K);
            end else begin
                check("seq_first_valid", inst_valid, 0);
            end
        end

        // Back-pressure: two entries buffered, fetch stalls, then resumes at 8.
        inst_ready = 1'b0;
        do_reset();
        tick();
        check("bp_addr0", mem_addr, 0);
        tick();
        check("bp_pc0", inst_pc, 0);
        check("bp_addr4", mem_addr, 4);
        tick();
        check("bp_stall_req", mem_req, 0);
        check("bp_head_pc", inst_pc, 0);
        tick();
        check("bp_stall_req2", mem_req, 0);
        inst_ready = 1'b1;
        tick();
        check("bp_resume_req", mem_req, 1);
        check("bp_resume_addr", mem_addr, 8);
        check("bp_pc4", inst_pc, 4);
        tick();
        check("bp_pc8", inst_pc, 8);

        // 3-cycle memory, redirect one cycle into the request to 0x8.
        inst_ready = 1'b1;
        lat = 2;
        do_reset();
        for (int g = 0; g < 30 && !(mem_req && mem_addr == 32'h8); g++) tick();
        check("drop_reach8", mem_addr, 32'h8);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        check("drop_flush", inst_valid, 0);
        check("drop_hold_addr", mem_addr, 32'h8);
        check("drop_hold_req", mem_req, 1);
        tick();
        check("drop_new_addr", mem_addr, 32'h100);
        check("drop_discarded", inst_valid, 0);
        for (int g = 0; g < 20 && !inst_valid; g++) tick();
        check("drop_valid", inst_valid, 1);
        check("drop_pc", inst_pc, 32'h100);
        check("drop_data", inst_data, 32'h100 ^ K);

        // Redirect coincident with the ack that would fill the FIFO.
        inst_ready = 1'b0;
        lat = 2;
        do_reset();
        for (int g = 0; g < 30 && !(mem_addr == 32'h4 && mem_ack); g++) tick();
        check("full_addr4", mem_addr, 32'h4);
        check("full_head_valid", inst_valid, 1);
        check("full_head_pc", inst_pc, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("full_flush", inst_valid, 0);
        check("full_new_addr", mem_addr, 32'h40);
        check("full_new_req", mem_req, 1);
        inst_ready = 1'b1;
        for (int g = 0; g < 20 && !inst_valid; g++) tick();
        check("full_next_pc", inst_pc, 32'h40);

        // Pointer wrap at the top of the address space.
        inst_ready = 1'b1;
        lat = 0;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("wrap_idle_req", mem_req, 0);
        tick();
        check("wrap_addr_top", mem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_zero", mem_addr, 32'h0);
        check("wrap_pc_top", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc_zero", inst_pc, 32'h0);
`ifndef IFETCH_MISALIGN_CHECK_EN
        // Low redirect bits ignored; redirect coincident with a zero-wait ack.
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        tick();
        redirect_valid = 1'b0;
        check("align_flush", inst_valid, 0);
        check("align_addr", mem_addr, 32'h200);
        tick();
        check("align_pc", inst_pc, 32'h200);
        check("align_data", inst_data, 32'h200 ^ K);
`endif

        // Reset mid-request, late acks ignored, redirect while in DROP.
        auto_en = 1'b0;
        inst_ready = 1'b1;
        do_reset();
        tick();
        check("late_req", mem_req, 1);
        tick();
        reset = 1'b0;
        tick();
        check("late_abandon", mem_req, 0);
        man_ack = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        check("late_req_again", mem_req, 1);
        check("late_addr", mem_addr, 0);
        check("late_no_push", inst_valid, 0);
        man_ack = 1'b0;
        tick();
        check("late_no_push2", inst_valid, 0);
        man_ack = 1'b1;
        tick();
        check("man_valid", inst_valid, 1);
        check("man_pc", inst_pc, 0);
        check("man_addr", mem_addr, 4);
        man_ack = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        check("ddrop_flush", inst_valid, 0);
        check("ddrop_hold", mem_addr, 4);
        redirect_pc = 32'h380;
        tick();
        check("ddrop_hold2", mem_addr, 4);
        check("ddrop_req", mem_req, 1);
        redirect_valid = 1'b0;
        man_ack = 1'b1;
        tick();
        check("ddrop_new_addr", mem_addr, 32'h380);
        check("ddrop_discard", inst_valid, 0);
        man_ack = 1'b0;

`ifdef IFETCH_MISALIGN_CHECK_EN
        // Misaligned redirect: error entry, fetch halted until the next redirect.
        auto_en = 1'b1;
        lat = 0;
        inst_ready = 1'b0;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        tick();
        redirect_valid = 1'b0;
        check("mis_valid", inst_valid, 1);
        check("mis_pc", inst_pc, 32'h102);
        check("mis_data", inst_data, 0);
        check("mis_flag", inst_misaligned, 1);
        for (int i = 0; i < 3; i++) begin
            check("mis_halt_req", mem_req, 0);
            tick();
        end
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        check("mis_cleared", inst_valid, 0);
        tick();
        check("mis_resume_req", mem_req, 1);
        check("mis_resume_addr", mem_addr, 32'h200);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
